// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// fetch_queue_pkg : shared constants for the instruction prefetch queue
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

  localparam int          c_default_width = 32;
  // Also sized against by the hazard unit; keep the two in step.
  localparam int          c_default_depth = 4;
  localparam logic [31:0] c_nop_instr     = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_mem.sv
// ============================================================================
// fetch_queue_mem : DEPTH x DATA_W storage, write on push, async read
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = c_default_depth,
  parameter int DATA_W = 2 * c_default_width
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : in-order {pc, instr} prefetch FIFO between fetch and decode
// Optional zero-latency bypass when empty: define FETCH_QUEUE_BYPASS_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = c_default_depth,
  parameter int WIDTH = c_default_width
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_fetch_valid,
  input  logic [WIDTH-1:0]         i_fetch_pc,
  input  logic [WIDTH-1:0]         i_fetch_instr,
  output logic                     o_fetch_ready,
  input  logic                     i_flush,
  input  logic                     i_decode_ready,
  output logic                     o_decode_valid,
  output logic [WIDTH-1:0]         o_decode_pc,
  output logic [WIDTH-1:0]         o_decode_instr,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_stored;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bypass;
  logic                 w_bypass_take;
  logic [2*WIDTH-1:0]   w_head;

  assign w_stored      = (r_count != '0);
  // Registered-only: no path from i_decode_ready, so a full queue refuses
  // a push even when a pop happens in the same cycle.
  assign o_fetch_ready = (r_count != c_full);
  assign w_pop         = w_stored & i_decode_ready & ~i_flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = ~w_stored & i_fetch_valid & ~i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed pair that decode consumes immediately is never stored.
  assign w_bypass_take = w_bypass & i_decode_ready;
  assign w_push        = i_fetch_valid & o_fetch_ready & ~i_flush & ~w_bypass_take;

  fetch_queue_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (2 * WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({i_fetch_pc, i_fetch_instr}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_comb begin
    o_decode_valid = 1'b0;
    o_decode_pc    = '0;
    o_decode_instr = WIDTH'(c_nop_instr);
    if (w_stored) begin
      o_decode_valid = 1'b1;
      o_decode_pc    = w_head[2*WIDTH-1:WIDTH];
      o_decode_instr = w_head[WIDTH-1:0];
    end else if (w_bypass) begin
      o_decode_valid = 1'b1;
      o_decode_pc    = i_fetch_pc;
      o_decode_instr = i_fetch_instr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire
